// File: rtl/dp_ram_burst_reader_if.sv
// Command, RAM read-port and output-stream bundle for dp_ram_burst_reader.
// Defining RD_STRIDE_EN adds the per-burst rd_stride field.
interface dp_ram_burst_reader_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int LW = 16
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] burst_len;
`ifdef RD_STRIDE_EN
  logic [AW-1:0] rd_stride;
`endif
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport slave (
    input  start, base_addr, burst_len, q, out_ready,
`ifdef RD_STRIDE_EN
    input  rd_stride,
`endif
    output rdaddress, out_data, out_valid, busy, done
  );

  modport master (
    output start, base_addr, burst_len, q, out_ready,
`ifdef RD_STRIDE_EN
    output rd_stride,
`endif
    input  rdaddress, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/dp_ram_burst_reader.sv
// Burst read controller for the fixed-latency dual-port RAM: issues addresses under FIFO credit,
// catches returned words in an output FIFO. RD_STRIDE_EN enables a per-burst address stride.
module dp_ram_burst_reader #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int LW       = 16,
  parameter int RD_LAT   = 2,
  parameter int FIFO_DEP = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  dp_ram_burst_reader_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEP);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_stride;
  logic [LW-1:0]   r_remain;
  logic [RD_LAT:0] r_vld_pipe;
  logic [DW-1:0]   r_mem [FIFO_DEP];
  logic [PW-1:0]   r_wp, r_rp;
  logic [PW:0]     r_cnt;
  logic            w_push, w_pop, w_load, w_issue;
  logic [CW-1:0]   w_inflight, w_occ;

`ifdef RD_STRIDE_EN
  logic [AW-1:0] r_stride;
  always_ff @(posedge clock) begin
    if (rst)         r_stride <= '0;
    else if (w_load) r_stride <= bus.rd_stride;
  end
  assign w_stride = r_stride;
`else
  assign w_stride = AW'(1);
`endif

  // Address register counts as the first latency stage, so the tail is RD_LAT edges behind it.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  assign w_push = r_vld_pipe[RD_LAT];
  assign w_pop  = bus.out_valid && bus.out_ready;
  // Counting this cycle's pop as a free slot keeps 1 word/cycle with FIFO_DEP = RD_LAT+2.
  assign w_occ  = CW'(r_cnt) + w_inflight - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.burst_len == '0) w_next = S_FIN;
          else begin
            w_load = 1'b1;
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (r_remain == '0) w_next = S_DRAIN;
        else if (w_occ < CW'(FIFO_DEP)) begin
          w_issue = 1'b1;
          if (r_remain == LW'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_vld_pipe == '0 && (r_cnt == '0 || (r_cnt == (PW+1)'(1) && w_pop)))
          w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_load | w_issue};
      if (w_load) begin
        r_addr   <= bus.base_addr;
        r_remain <= bus.burst_len - LW'(1);
      end else if (w_issue) begin
        r_addr   <= r_addr + w_stride;
        r_remain <= r_remain - LW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= bus.q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  assign bus.rdaddress = r_addr;
  assign bus.out_data  = r_mem[r_rp];
  assign bus.out_valid = (r_cnt != '0);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);
endmodule
